baud_gen_frac: RTL and testbench

Programmable fractional baud-tick generator for the UART TX/RX datapath. It produces an oversample tick (os_tick) whose average period is DIV_INT + DIV_FRAC/2^FRAC_W clocks, and a bit tick (bit_tick) on every OVERSAMPLE-th os_tick. The divisor is loadable at run time through a valid/ready handshake, so baud rate changes need no re-synthesis. It replaces the fixed compile-time divisor generator, and its ticks feed the receiver sampler and the transmitter shifter.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/baud_frac_acc.sv | 38 +++
 rtl/baud_gen_frac.sv | 106 ++++++++++
 tb/tb_baud_gen_frac.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, divisor type and reset-divisor helper
package uart_pkg;

  localparam int INT_W      = 16;
  localparam int FRAC_W     = 4;
  localparam int OVERSAMPLE = 16;

  typedef struct packed {
    logic [INT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
  } div_t;

  // Rounded clk_freq / (baud_rate * OVERSAMPLE) in INT_W.FRAC_W fixed point.
  function automatic div_t calc_div(input longint unsigned clk_freq,
                                    input longint unsigned baud_rate);
    longint unsigned den;
    longint unsigned scaled;
    div_t d;
    den        = baud_rate * longint'(OVERSAMPLE);
    scaled     = ((clk_freq << FRAC_W) + (den >> 1)) / den;
    d.div_int  = scaled[FRAC_W +: INT_W];
    d.div_frac = scaled[FRAC_W-1:0];
    return d;
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// rtl/baud_frac_acc.sv - fractional accumulator that stretches every carry period by one clock
module baud_frac_acc #(
  parameter int INT_W  = uart_pkg::INT_W,
  parameter int FRAC_W = uart_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              step,
  input  logic              clear,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic [INT_W:0]    len
);

  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, div_frac};
  assign len = {1'b0, div_int} + {{INT_W{1'b0}}, carry};

  // A freshly applied divisor starts from acc=0 so its first period is exactly div_int.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (step) begin
      if (clear) begin
        acc   <= '0;
        carry <= 1'b0;
      end else begin
        {carry, acc} <= sum;
      end
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - programmable fractional oversample/bit tick generator
module baud_gen_frac #(
  parameter int INT_W        = uart_pkg::INT_W,
  parameter int FRAC_W       = uart_pkg::FRAC_W,
  parameter int OVERSAMPLE   = uart_pkg::OVERSAMPLE,
  parameter int DIV_INT_RST  = 6,
  parameter int DIV_FRAC_RST = 13,
  localparam int PH_W        = $clog2(OVERSAMPLE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INT_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              cfg_err,
  output logic              os_tick,
  output logic              bit_tick,
  output logic [PH_W-1:0]   os_phase
);

  logic [INT_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [INT_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_frac;
  logic              pend_valid;
  logic [INT_W:0]    cnt;
  logic [INT_W:0]    len;

  logic xfer, legal, period_end, last_phase;
  logic load_now, stash, apply_pend;

  assign xfer       = cfg_valid && cfg_ready;
  assign legal      = xfer && (cfg_div_int != '0);
  assign period_end = en && (cnt == len - (INT_W+1)'(1));
  assign last_phase = (os_phase == PH_W'(OVERSAMPLE - 1));

  // Divisors take effect only at a period boundary while running, immediately while idle.
  assign load_now   = legal && (!en || period_end);
  assign stash      = legal && en && !period_end;
  assign apply_pend = pend_valid && (!en || period_end);

  baud_frac_acc #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .step     (period_end),
    .clear    (load_now || apply_pend),
    .div_int  (act_int),
    .div_frac (act_frac),
    .len      (len)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      os_phase   <= '0;
      os_tick    <= 1'b0;
      bit_tick   <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      pend_valid <= 1'b0;
      pend_int   <= '0;
      pend_frac  <= '0;
      act_int    <= INT_W'(DIV_INT_RST);
      act_frac   <= FRAC_W'(DIV_FRAC_RST);
    end else begin
      cfg_err  <= xfer && (cfg_div_int == '0);
      os_tick  <= period_end;
      bit_tick <= period_end && last_phase;

      if (!en) begin
        cnt      <= '0;
        os_phase <= '0;
      end else if (period_end) begin
        cnt      <= '0;
        os_phase <= last_phase ? '0 : os_phase + PH_W'(1);
      end else begin
        cnt      <= cnt + (INT_W+1)'(1);
      end

      if (load_now) begin
        act_int  <= cfg_div_int;
        act_frac <= cfg_div_frac;
      end else if (apply_pend) begin
        act_int  <= pend_int;
        act_frac <= pend_frac;
      end

      if (stash) begin
        pend_int   <= cfg_div_int;
        pend_frac  <= cfg_div_frac;
        pend_valid <= 1'b1;
        cfg_ready  <= 1'b0;
      end else if (apply_pend) begin
        pend_valid <= 1'b0;
        cfg_ready  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - directed-vector bench for baud_gen_frac
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_div_int = '0;
  logic [3:0]  cfg_div_frac = '0;
  logic        cfg_ready, cfg_err, os_tick, bit_tick;
  logic [3:0]  os_phase;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  baud_gen_frac dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_err      (cfg_err),
    .os_tick      (os_tick),
    .bit_tick     (bit_tick),
    .os_phase     (os_phase)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!os_tick && n < limit);
  endtask

  task automatic load_idle(input int i, input int f);
    en           = 1'b0;
    cfg_valid    = 1'b1;
    cfg_div_int  = 16'(i);
    cfg_div_frac = 4'(f);
    step();
    cfg_valid    = 1'b0;
  endtask

  initial begin
    int n;
    int span;

    // reset state
    step();
    step();
    check("rst_os_tick", os_tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_os_phase", os_phase, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    reset = 1'b0;

    // 1: integer divisor 4
    load_idle(4, 0);
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wait_tick(100, n);
      check("t1_gap", n, 4);
      check("t1_phase", os_phase, i % 16);
      check("t1_bit", bit_tick, (i == 16));
    end

    // 2: 6 + 8/16
    load_idle(6, 8);
    en = 1'b1;
    span = 0;
    for (int k = 1; k <= 17; k++) begin
      wait_tick(100, n);
      check("t2_gap", n, (k >= 3 && (k % 2) == 1) ? 7 : 6);
      if (k >= 2) span += n;
    end
    check("t2_span16", span, 104);

    // 3: load 10 mid-period while running
    step();
    step();
    cfg_valid    = 1'b1;
    cfg_div_int  = 16'd10;
    cfg_div_frac = 4'd0;
    step();
    cfg_valid = 1'b0;
    check("t3_ready_low0", cfg_ready, 0);
    step();
    check("t3_ready_low1", cfg_ready, 0);
    check("t3_no_tick", os_tick, 0);
    step();
    check("t3_ready_low2", cfg_ready, 0);
    wait_tick(100, n);
    check("t3_old_end", n, 1);
    check("t3_ready_back", cfg_ready, 1);
    wait_tick(100, n);
    check("t3_gap_a", n, 10);
    wait_tick(100, n);
    check("t3_gap_b", n, 10);

    // 4: illegal divisor
    step();
    step();
    step();
    cfg_valid    = 1'b1;
    cfg_div_int  = 16'd0;
    cfg_div_frac = 4'd3;
    step();
    cfg_valid = 1'b0;
    check("t4_err_pulse", cfg_err, 1);
    check("t4_ready", cfg_ready, 1);
    step();
    check("t4_err_clear", cfg_err, 0);
    wait_tick(100, n);
    check("t4_gap_rest", n, 5);
    wait_tick(100, n);
    check("t4_gap_full", n, 10);

    // 5: en low for 3 cycles mid-period
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_idle_tick", os_tick, 0);
      check("t5_idle_phase", os_phase, 0);
    end
    en = 1'b1;
    wait_tick(100, n);
    check("t5_restart_gap", n, 10);
    check("t5_restart_phase", os_phase, 1);

    // 6: reset with a divisor pending
    step();
    step();
    cfg_valid    = 1'b1;
    cfg_div_int  = 16'd20;
    cfg_div_frac = 4'd0;
    step();
    cfg_valid = 1'b0;
    check("t6_pending", cfg_ready, 0);
    reset = 1'b1;
    step();
    check("t6_os_tick", os_tick, 0);
    check("t6_bit_tick", bit_tick, 0);
    check("t6_cfg_err", cfg_err, 0);
    check("t6_os_phase", os_phase, 0);
    check("t6_cfg_ready", cfg_ready, 1);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      wait_tick(100, n);
      check("t6_gap", n, (k <= 2 || k == 7) ? 6 : 7);
    end

    // 8: transfer coinciding with a period end
    load_idle(4, 0);
    en = 1'b1;
    wait_tick(100, n);
    check("t8_first", n, 4);
    step();
    step();
    step();
    cfg_valid    = 1'b1;
    cfg_div_int  = 16'd5;
    cfg_div_frac = 4'd0;
    step();
    cfg_valid = 1'b0;
    check("t8_tick", os_tick, 1);
    check("t8_ready", cfg_ready, 1);
    wait_tick(100, n);
    check("t8_gap_a", n, 5);
    wait_tick(100, n);
    check("t8_gap_b", n, 5);

    // 7: int=1 frac=0 ticks every clock
    load_idle(1, 0);
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("t7_tick", os_tick, 1);
      check("t7_phase", os_phase, i % 16);
      check("t7_bit", bit_tick, (i == 16));
    end
    en = 1'b0;
    step();
    check("t7_stop", os_tick, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
